// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared types and limits for the truth-table sweeper
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } tt_state_t;

  localparam int TT_MAX_N_IN = 6;

endpackage

// File: rtl/tt_hold_timer.sv
// rtl/tt_hold_timer.sv - per-minterm hold counter, ticks on the last cycle of each hold window
module tt_hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  logic [7:0] hold_cnt;

  assign tick = en && (hold_cnt == 8'(HOLD_CYCLES - 1));

  // Count up while enabled, wrap on tick; held at zero outside a sweep so
  // every new sweep starts with a full hold window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (!en || tick) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps all minterms, captures f, compares to golden (option: TT_FIRST_FAIL_EN)
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int N_IN        = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  input  logic                   f,
  output logic [N_IN-1:0]        stim,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(1<<N_IN)-1:0]   captured
`ifdef TT_FIRST_FAIL_EN
  ,
  output logic                   fail_valid,
  output logic [N_IN-1:0]        first_fail
`endif
);

  localparam int W = 1 << N_IN;

  if (N_IN < 2 || N_IN > TT_MAX_N_IN) begin : g_bad_n_in
    $error("truth_table_sweeper: N_IN out of range");
  end
  if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("truth_table_sweeper: HOLD_CYCLES out of range");
  end

  tt_state_t       state, state_next;
  logic [N_IN-1:0] idx;
  logic [W-1:0]    exp_q;
  logic [W-1:0]    captured_next;
  logic            accept;
  logic            tick;
  logic            last;

  assign last = (idx == {N_IN{1'b1}});

  tt_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (busy),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and state-derived outputs; start outside IDLE is dropped.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_next = DRIVE;
        accept     = 1'b1;
      end
      DRIVE: if (tick && last) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy = (state == DRIVE);
    done = (state == DONE);
    stim = busy ? idx : '0;
  end

  // Capture vector including the bit being sampled this cycle, so the final
  // compare sees all minterms in the same edge that moves us to DONE.
  always_comb begin
    captured_next      = captured;
    captured_next[idx] = f;
  end

`ifdef TT_FIRST_FAIL_EN
  function automatic logic [N_IN-1:0] lowest_set(input logic [W-1:0] v);
    lowest_set = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = N_IN'(i);
    end
  endfunction
`endif

  // Minterm index, capture register and registered compare results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      captured <= '0;
      exp_q    <= '0;
      pass     <= 1'b0;
`ifdef TT_FIRST_FAIL_EN
      fail_valid <= 1'b0;
      first_fail <= '0;
`endif
    end else if (accept) begin
      idx      <= '0;
      captured <= '0;
      exp_q    <= expected;
      pass     <= 1'b0;
`ifdef TT_FIRST_FAIL_EN
      fail_valid <= 1'b0;
      first_fail <= '0;
`endif
    end else if (tick) begin
      captured <= captured_next;
      if (last) begin
        pass <= (captured_next == exp_q);
`ifdef TT_FIRST_FAIL_EN
        fail_valid <= (captured_next != exp_q);
        first_fail <= lowest_set(captured_next ^ exp_q);
`endif
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - directed self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] expected;
  logic        f;
  logic [3:0]  stim;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] captured;
`ifdef TT_FIRST_FAIL_EN
  logic        fail_valid;
  logic [3:0]  first_fail;
`endif

  int tests;
  int fails;

  logic mode;
  logic d1, d2;

  truth_table_sweeper #(.N_IN(4), .HOLD_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .expected   (expected),
    .f          (f),
    .stim       (stim),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .captured   (captured)
`ifdef TT_FIRST_FAIL_EN
    ,
    .fail_valid (fail_valid),
    .first_fail (first_fail)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    d1 <= stim[3];
    d2 <= d1;
  end

  assign f = mode ? d2 : ^stim;

  int lat;
  int ndone;
  logic busy_mid;
  logic pass_at_done;

  task automatic run_sweep(input logic [15:0] exp_v, input int pulse_at);
    @(negedge clk);
    expected = exp_v;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    lat          = -1;
    ndone        = 0;
    busy_mid     = 1'b0;
    pass_at_done = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (c == pulse_at) begin
        start    = 1'b1;
        expected = 16'h0000;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (c == 32) busy_mid = busy;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat          = c;
          pass_at_done = pass;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, pass, stim, captured} !== 23'd0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b pass=%b stim=%h captured=%h, want all 0",
               busy, done, pass, stim, captured);
    end
`ifdef TT_FIRST_FAIL_EN
    tests++;
    if ({fail_valid, first_fail} !== 5'd0) begin
      fails++;
      $display("FAIL reset_first_fail: got fv=%b ff=%h, want 0", fail_valid, first_fail);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, pass, stim, captured} !== 23'd0) begin
      fails++;
      $display("FAIL idle_no_start: got busy=%b done=%b pass=%b stim=%h captured=%h, want all 0",
               busy, done, pass, stim, captured);
    end
  endtask

  task automatic test_pass_case();
    mode = 1'b0;
    run_sweep(16'h6996, -1);
    tests++;
    if (lat !== 64) begin
      fails++;
      $display("FAIL pass_latency: got %0d, want 64", lat);
    end
    tests++;
    if (busy_mid !== 1'b1) begin
      fails++;
      $display("FAIL pass_busy_mid: got %b, want 1", busy_mid);
    end
    tests++;
    if (pass_at_done !== 1'b1) begin
      fails++;
      $display("FAIL pass_at_done: got %b, want 1", pass_at_done);
    end
    tests++;
    if (captured !== 16'h6996) begin
      fails++;
      $display("FAIL pass_captured: got %h, want 6996", captured);
    end
    tests++;
    if (ndone !== 1 || busy !== 1'b0 || pass !== 1'b1) begin
      fails++;
      $display("FAIL pass_after: got ndone=%0d busy=%b pass=%b, want 1 0 1", ndone, busy, pass);
    end
  endtask

  task automatic test_fail_case();
    mode = 1'b0;
    run_sweep(16'h6997, -1);
    tests++;
    if (pass !== 1'b0 || captured !== 16'h6996) begin
      fails++;
      $display("FAIL fail_case: got pass=%b captured=%h, want 0 6996", pass, captured);
    end
    tests++;
    if (lat !== 64) begin
      fails++;
      $display("FAIL fail_latency: got %0d, want 64", lat);
    end
`ifdef TT_FIRST_FAIL_EN
    tests++;
    if (fail_valid !== 1'b1 || first_fail !== 4'd0) begin
      fails++;
      $display("FAIL first_fail: got fv=%b ff=%0d, want 1 0", fail_valid, first_fail);
    end
`endif
  endtask

  task automatic test_start_while_busy();
    mode = 1'b0;
    run_sweep(16'h6996, 10);
    tests++;
    if (lat !== 64) begin
      fails++;
      $display("FAIL busy_start_latency: got %0d, want 64", lat);
    end
    tests++;
    if (ndone !== 1) begin
      fails++;
      $display("FAIL busy_start_done_count: got %0d, want 1", ndone);
    end
    tests++;
    if (pass !== 1'b1) begin
      fails++;
      $display("FAIL busy_start_expected_latched: got pass=%b, want 1", pass);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int nd;
    mode = 1'b0;
    @(negedge clk);
    expected = 16'h6996;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    tests++;
    if (stim !== 4'd7) begin
      fails++;
      $display("FAIL mid_idx: got stim=%0d, want 7", stim);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, pass, stim, captured} !== 23'd0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got busy=%b done=%b pass=%b stim=%h captured=%h, want all 0",
               busy, done, pass, stim, captured);
    end
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    tests++;
    if (nd !== 0) begin
      fails++;
      $display("FAIL mid_no_done: got %0d done pulses, want 0", nd);
    end
    run_sweep(16'h6996, -1);
    tests++;
    if (lat !== 64 || captured !== 16'h6996 || pass !== 1'b1) begin
      fails++;
      $display("FAIL mid_rerun: got lat=%0d captured=%h pass=%b, want 64 6996 1", lat, captured, pass);
    end
  endtask

  task automatic test_sample_point();
    mode = 1'b1;
    run_sweep(16'hFF00, -1);
    tests++;
    if (captured !== 16'hFF00) begin
      fails++;
      $display("FAIL sample_captured: got %h, want ff00", captured);
    end
    tests++;
    if (pass !== 1'b1) begin
      fails++;
      $display("FAIL sample_pass: got %b, want 1", pass);
    end
    mode = 1'b0;
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    mode     = 1'b0;
    start    = 1'b0;
    expected = 16'h0000;
    rst_n    = 1'b0;
    test_reset();
    test_pass_case();
    test_fail_case();
    test_start_while_busy();
    test_reset_mid_sweep();
    test_sample_point();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
